// File: rtl/dmi_jtag_dtm_if.sv
// DMI bus between the JTAG debug transport module (master) and the Debug Module (slave).
interface dmi_jtag_dtm_if #(
   parameter int ADDRESS_SIZE = 7
);
   logic [ADDRESS_SIZE-1:0] DMI_raddr;
   logic [ADDRESS_SIZE-1:0] DMI_waddr;
   logic [31:0]             DMI_wdata;
   logic                    write_en;
   logic                    read_en;
   logic [31:0]             rdata;

   modport master (
      output DMI_raddr, DMI_waddr, DMI_wdata, write_en, read_en,
      input  rdata
   );

   modport slave (
      input  DMI_raddr, DMI_waddr, DMI_wdata, write_en, read_en,
      output rdata
   );
endinterface

// File: rtl/dmi_jtag_dtm.sv
// JTAG DTM running entirely in the clk domain: oversampled TAP, IR, IDCODE/dtmcs/dmi/BYPASS.
// Optional TAP reset pin trst_n is enabled by defining DMI_JTAG_DTM_TRST_EN.
module dmi_jtag_dtm #(
   parameter int          ADDRESS_SIZE = 7,
   parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001,
   parameter int          SYNC_STAGES  = 2
) (
   input  logic clk,
   input  logic reset,
`ifdef DMI_JTAG_DTM_TRST_EN
   input  logic trst_n,
`endif
   input  logic tck,
   input  logic tms,
   input  logic tdi,
   output logic tdo,
   dmi_jtag_dtm_if.master dmi
);

   localparam int         DMI_W     = ADDRESS_SIZE + 34;
   localparam logic [4:0] IR_IDCODE = 5'h01;
   localparam logic [4:0] IR_DTMCS  = 5'h10;
   localparam logic [4:0] IR_DMI    = 5'h11;

   typedef enum logic [3:0] {
      TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
      SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
   } tap_state_t;

   typedef enum logic [1:0] {SEL_IDCODE, SEL_DTMCS, SEL_DMI, SEL_BYPASS} dr_sel_t;

   logic [SYNC_STAGES-1:0]  tck_sync, tms_sync, tdi_sync;
   logic                    tck_prev, tck_s, tms_s, tdi_s, tck_rise, tck_fall;
   logic                    tap_reset;
   tap_state_t              tap_state, tap_next;
   logic                    capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;
   logic [4:0]              ir, ir_shift;
   dr_sel_t                 dr_sel;
   logic [DMI_W-1:0]        dr_shift, dr_shifted, dr_capture;
   logic [31:0]             dtmcs_cap;
   logic [1:0]              dmi_op_cap;
   logic [1:0]              dmistat;
   logic                    rd_wait, pending;
   logic [31:0]             captured_data;
   logic [ADDRESS_SIZE-1:0] last_addr;
   logic                    dmi_update, dtmcs_update, hard_reset;

   // Pin oversampling; edges are detected on the last synchronizer stage only.
   always_ff @(posedge clk) begin
      if (!reset) begin
         tck_sync <= '0;
         tms_sync <= '0;
         tdi_sync <= '0;
         tck_prev <= 1'b0;
      end else begin
         // NOTE: sequential state uses <= so every flop samples pre-edge values in parallel.
         tck_sync <= {tck_sync[SYNC_STAGES-2:0], tck};
         tms_sync <= {tms_sync[SYNC_STAGES-2:0], tms};
         tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], tdi};
         tck_prev <= tck_s;
      end
   end

   assign tck_s    = tck_sync[SYNC_STAGES-1];
   assign tms_s    = tms_sync[SYNC_STAGES-1];
   assign tdi_s    = tdi_sync[SYNC_STAGES-1];
   assign tck_rise = tck_s & ~tck_prev;
   assign tck_fall = ~tck_s & tck_prev;

`ifdef DMI_JTAG_DTM_TRST_EN
   logic [SYNC_STAGES-1:0] trst_sync;
   always_ff @(posedge clk) begin
      if (!reset) trst_sync <= '1;
      else        trst_sync <= {trst_sync[SYNC_STAGES-2:0], trst_n};
   end
   assign tap_reset = ~trst_sync[SYNC_STAGES-1];
`else
   assign tap_reset = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset || tap_reset) tap_state <= TLR;
      else if (tck_rise)       tap_state <= tap_next;
   end

   always_comb begin
      // NOTE: a default before the case keeps this purely combinational (no latch).
      tap_next = tap_state;
      case (tap_state)
         TLR:    tap_next = tms_s ? TLR    : RTI;
         RTI:    tap_next = tms_s ? SEL_DR : RTI;
         SEL_DR: tap_next = tms_s ? SEL_IR : CAP_DR;
         CAP_DR: tap_next = tms_s ? EX1_DR : SH_DR;
         SH_DR:  tap_next = tms_s ? EX1_DR : SH_DR;
         EX1_DR: tap_next = tms_s ? UPD_DR : PAU_DR;
         PAU_DR: tap_next = tms_s ? EX2_DR : PAU_DR;
         EX2_DR: tap_next = tms_s ? UPD_DR : SH_DR;
         UPD_DR: tap_next = tms_s ? SEL_DR : RTI;
         SEL_IR: tap_next = tms_s ? TLR    : CAP_IR;
         CAP_IR: tap_next = tms_s ? EX1_IR : SH_IR;
         SH_IR:  tap_next = tms_s ? EX1_IR : SH_IR;
         EX1_IR: tap_next = tms_s ? UPD_IR : PAU_IR;
         PAU_IR: tap_next = tms_s ? EX2_IR : PAU_IR;
         EX2_IR: tap_next = tms_s ? UPD_IR : SH_IR;
         UPD_IR: tap_next = tms_s ? SEL_DR : RTI;
         default: tap_next = TLR;
      endcase
   end

   // Capture/shift/update act on the tck rise that leaves the corresponding state.
   always_comb begin
      capture_dr = (tap_state == CAP_DR);
      shift_dr   = (tap_state == SH_DR);
      update_dr  = (tap_state == UPD_DR);
      capture_ir = (tap_state == CAP_IR);
      shift_ir   = (tap_state == SH_IR);
      update_ir  = (tap_state == UPD_IR);
   end

   always_comb begin
      case (ir)
         IR_IDCODE: dr_sel = SEL_IDCODE;
         IR_DTMCS:  dr_sel = SEL_DTMCS;
         IR_DMI:    dr_sel = SEL_DMI;
         default:   dr_sel = SEL_BYPASS;
      endcase
   end

   assign pending = dmi.read_en | rd_wait | dmi.write_en;

   always_comb begin
      dmi_op_cap = pending ? 2'd3 : dmistat;
      dtmcs_cap  = {14'b0, 3'b0, 3'd1, dmistat, 6'(ADDRESS_SIZE), 4'd1};
      case (dr_sel)
         SEL_IDCODE: dr_capture = DMI_W'(IDCODE_VALUE);
         SEL_DTMCS:  dr_capture = DMI_W'(dtmcs_cap);
         SEL_DMI:    dr_capture = {last_addr, captured_data, dmi_op_cap};
         default:    dr_capture = '0;
      endcase
   end

   // One shared shift register; tdi enters at the top bit of the selected register.
   always_comb begin
      dr_shifted = dr_shift >> 1;
      case (dr_sel)
         SEL_DMI:    dr_shifted[DMI_W-1] = tdi_s;
         SEL_BYPASS: dr_shifted[0]       = tdi_s;
         default:    dr_shifted[31]      = tdi_s;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset || tap_reset) begin
         ir       <= IR_IDCODE;
         ir_shift <= '0;
         dr_shift <= '0;
         tdo      <= 1'b0;
      end else begin
         if (tck_rise) begin
            if (tap_state == TLR) ir <= IR_IDCODE;
            if (update_ir)        ir <= ir_shift;
            if (capture_ir)       ir_shift <= 5'b00001;
            else if (shift_ir)    ir_shift <= {tdi_s, ir_shift[4:1]};
            if (capture_dr)       dr_shift <= dr_capture;
            else if (shift_dr)    dr_shift <= dr_shifted;
         end
         if (tck_fall) begin
            if (shift_ir)      tdo <= ir_shift[0];
            else if (shift_dr) tdo <= dr_shift[0];
         end
      end
   end

   assign dmi_update   = tck_rise & update_dr & (dr_sel == SEL_DMI) & ~tap_reset;
   assign dtmcs_update = tck_rise & update_dr & (dr_sel == SEL_DTMCS) & ~tap_reset;
   assign hard_reset   = dtmcs_update & dr_shift[17];

   // DMI side: only the system reset clears it, the TAP reset leaves it alone.
   always_ff @(posedge clk) begin
      if (!reset) begin
         dmi.read_en   <= 1'b0;
         dmi.write_en  <= 1'b0;
         dmi.DMI_raddr <= '0;
         dmi.DMI_waddr <= '0;
         dmi.DMI_wdata <= '0;
         rd_wait       <= 1'b0;
         dmistat       <= 2'd0;
         captured_data <= '0;
         last_addr     <= '0;
      end else begin
         dmi.read_en  <= 1'b0;
         dmi.write_en <= 1'b0;
         rd_wait      <= dmi.read_en & ~hard_reset;
         if (rd_wait && !hard_reset) captured_data <= dmi.rdata;
         if (tck_rise && capture_dr && dr_sel == SEL_DMI && pending) dmistat <= 2'd3;
         if (dtmcs_update && (dr_shift[16] || dr_shift[17])) dmistat <= 2'd0;
         if (dmi_update && dmistat == 2'd0) begin
            last_addr <= dr_shift[DMI_W-1:34];
            case (dr_shift[1:0])
               2'd1: begin
                  dmi.DMI_raddr <= dr_shift[DMI_W-1:34];
                  dmi.read_en   <= 1'b1;
               end
               2'd2: begin
                  dmi.DMI_waddr <= dr_shift[DMI_W-1:34];
                  dmi.DMI_wdata <= dr_shift[33:2];
                  dmi.write_en  <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dmi_jtag_dtm.sv
// Scoreboard bench for dmi_jtag_dtm: JTAG scans and DMI strobes are checked by a separate monitor.
module tb_dmi_jtag_dtm;
   localparam int          AW       = 7;
   localparam int          DMI_W    = AW + 34;
   localparam logic [31:0] IDCODE   = 32'h1000_0001;
   localparam int          TCK_HALF = 40;

   typedef struct {
      string       name;
      logic [63:0] val;
   } exp_t;

   logic clk = 1'b0, reset = 1'b0, tck = 1'b0, tms = 1'b1, tdi = 1'b0;
   logic tdo;
`ifdef DMI_JTAG_DTM_TRST_EN
   logic trst_n = 1'b1;
`endif

   dmi_jtag_dtm_if #(.ADDRESS_SIZE(AW)) dmi_bus ();

   dmi_jtag_dtm #(
      .ADDRESS_SIZE(AW),
      .IDCODE_VALUE(IDCODE),
      .SYNC_STAGES(2)
   ) dut (
      .clk(clk),
      .reset(reset),
`ifdef DMI_JTAG_DTM_TRST_EN
      .trst_n(trst_n),
`endif
      .tck(tck),
      .tms(tms),
      .tdi(tdi),
      .tdo(tdo),
      .dmi(dmi_bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   exp_t        scan_exp_q[$];
   logic [63:0] scan_act_q[$];
   exp_t        strobe_exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
      return 64'({a, d, op});
   endfunction

   // kind: 2'b10 write, 2'b01 read
   function automatic logic [63:0] strobe_word(input logic [1:0] kind, input logic [6:0] a, input logic [31:0] d);
      return {16'h0, 6'h0, kind, 1'b0, a, d};
   endfunction

   // Debug Module model: read data appears the cycle after read_en.
   logic [31:0] dm_mem [128];
   initial begin
      for (int i = 0; i < 128; i++) dm_mem[i] = 32'h0;
      dm_mem[7'h11] = 32'h0000_0C82;
      dmi_bus.rdata = 32'h0;
   end
   always @(posedge clk) begin
      if (dmi_bus.write_en) dm_mem[dmi_bus.DMI_waddr] <= dmi_bus.DMI_wdata;
      if (dmi_bus.read_en)  dmi_bus.rdata <= dm_mem[dmi_bus.DMI_raddr];
   end

   initial begin : monitor
      exp_t        e;
      logic [63:0] act;
      logic [1:0]  kind;
      forever begin
         @(negedge clk);
         if (dmi_bus.read_en || dmi_bus.write_en) begin
            kind = {dmi_bus.write_en, dmi_bus.read_en};
            act  = strobe_word(kind,
                               dmi_bus.write_en ? dmi_bus.DMI_waddr : dmi_bus.DMI_raddr,
                               dmi_bus.write_en ? dmi_bus.DMI_wdata : 32'h0);
            if (strobe_exp_q.size() == 0) check("unexpected_strobe", act, 64'h0);
            else begin
               e = strobe_exp_q.pop_front();
               check(e.name, act, e.val);
            end
         end
         while (scan_act_q.size() > 0) begin
            act = scan_act_q.pop_front();
            if (scan_exp_q.size() == 0) check("scan_without_expectation", act, ~act);
            else begin
               e = scan_exp_q.pop_front();
               check(e.name, act, e.val);
            end
         end
      end
   end

   task automatic tick(input logic tms_v, input logic tdi_v, output logic tdo_v);
      tms = tms_v;
      tdi = tdi_v;
      #(TCK_HALF);
      tdo_v = tdo;
      tck = 1'b1;
      #(TCK_HALF);
      tck = 1'b0;
   endtask

   task automatic scan_ir(input logic [4:0] v);
      logic b;
      logic [63:0] dout = '0;
      scan_exp_q.push_back('{name: "ir_capture", val: 64'h1});
      tick(1, 0, b); tick(1, 0, b); tick(0, 0, b); tick(0, 0, b);
      for (int i = 0; i < 5; i++) begin
         tick(i == 4, v[i], b);
         dout[i] = b;
      end
      tick(1, 0, b); tick(0, 0, b);
      scan_act_q.push_back(dout);
   endtask

   task automatic scan_dr(input string name, input logic [63:0] din, input int len, input logic [63:0] exp);
      logic b;
      logic [63:0] dout = '0;
      scan_exp_q.push_back('{name: name, val: exp});
      tick(1, 0, b); tick(0, 0, b); tick(0, 0, b);
      for (int i = 0; i < len; i++) begin
         tick(i == len - 1, din[i], b);
         dout[i] = b;
      end
      tick(1, 0, b); tick(0, 0, b);
      scan_act_q.push_back(dout);
   endtask

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic b;
      bit   seen;
      #2;
      repeat (4) @(posedge clk);
      #1;
      check("rst_tdo", 64'(tdo), 64'h0);
      check("rst_read_en", 64'(dmi_bus.read_en), 64'h0);
      check("rst_write_en", 64'(dmi_bus.write_en), 64'h0);
      check("rst_raddr", 64'(dmi_bus.DMI_raddr), 64'h0);
      check("rst_waddr_wdata", {25'h0, dmi_bus.DMI_waddr, dmi_bus.DMI_wdata}, 64'h0);
      #1;
      reset = 1'b1;

      // Test 1: five tms=1 clocks, then IDCODE scan
      repeat (5) tick(1, 0, b);
      tick(0, 0, b);
      scan_dr("idcode", 64'h0, 32, 64'(IDCODE));

      // Test 2: dtmcs capture
      scan_ir(5'h10);
      scan_dr("dtmcs_capture", 64'h0, 32, 64'h1071);

      // Undecoded IR falls back to BYPASS: one leading capture zero
      scan_ir(5'h07);
      scan_dr("bypass", 64'hA5, 8, 64'h4A);

      // Test 3: dmi write
      scan_ir(5'h11);
      strobe_exp_q.push_back('{name: "write_04", val: strobe_word(2'b10, 7'h04, 32'hDEAD_BEEF)});
      scan_dr("dmi_cap_initial", dmi_word(7'h04, 32'hDEAD_BEEF, 2'd2), DMI_W, dmi_word(7'h00, 32'h0, 2'd0));

      // Test 4: dmi read, then NOP to scan out the result
      strobe_exp_q.push_back('{name: "read_11", val: strobe_word(2'b01, 7'h11, 32'h0)});
      scan_dr("dmi_cap_after_write", dmi_word(7'h11, 32'h0, 2'd1), DMI_W, dmi_word(7'h04, 32'h0, 2'd0));
      scan_dr("dmi_read_result", dmi_word(7'h11, 32'h0, 2'd0), DMI_W, dmi_word(7'h11, 32'h0000_0C82, 2'd0));
      check("hold_waddr", 64'(dmi_bus.DMI_waddr), 64'h04);
      check("hold_wdata", 64'(dmi_bus.DMI_wdata), 64'hDEAD_BEEF);
      check("hold_raddr", 64'(dmi_bus.DMI_raddr), 64'h11);

      // Test 5: busy capture makes dmistat sticky until dmireset
      force dut.pending = 1'b1;
      scan_dr("dmi_cap_busy", dmi_word(7'h11, 32'h0, 2'd0), DMI_W, dmi_word(7'h11, 32'h0000_0C82, 2'd3));
      release dut.pending;
      scan_dr("dmi_cap_sticky", dmi_word(7'h11, 32'h1234_5678, 2'd2), DMI_W, dmi_word(7'h11, 32'h0000_0C82, 2'd3));
      scan_ir(5'h10);
      scan_dr("dtmcs_busy", 64'h1_0000, 32, 64'h1C71);
      scan_dr("dtmcs_cleared", 64'h0, 32, 64'h1071);
      scan_ir(5'h11);
      strobe_exp_q.push_back('{name: "write_05", val: strobe_word(2'b10, 7'h05, 32'h1234_5678)});
      scan_dr("dmi_cap_recovered", dmi_word(7'h05, 32'h1234_5678, 2'd2), DMI_W, dmi_word(7'h11, 32'h0000_0C82, 2'd0));

      // Test 6: reset during the write strobe
      strobe_exp_q.push_back('{name: "write_22", val: strobe_word(2'b10, 7'h22, 32'hCAFE_F00D)});
      seen = 1'b0;
      fork
         scan_dr("dmi_cap_before_reset", dmi_word(7'h22, 32'hCAFE_F00D, 2'd2), DMI_W,
                 dmi_word(7'h05, 32'h0000_0C82, 2'd0));
         begin
            for (int i = 0; i < 2000 && !seen; i++) begin
               @(posedge clk);
               #1;
               if (dmi_bus.write_en) seen = 1'b1;
            end
            check("write_seen_before_reset", 64'(seen), 64'h1);
            reset = 1'b0;
            @(posedge clk);
            #1;
            check("reset_write_en", 64'(dmi_bus.write_en), 64'h0);
            check("reset_waddr", 64'(dmi_bus.DMI_waddr), 64'h0);
            check("reset_wdata", 64'(dmi_bus.DMI_wdata), 64'h0);
         end
      join
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
      tick(0, 0, b);
      scan_dr("idcode_after_reset", 64'h0, 32, 64'(IDCODE));
      scan_ir(5'h11);
      scan_dr("dmi_cap_after_reset", 64'h0, DMI_W, dmi_word(7'h00, 32'h0, 2'd0));

      repeat (20) @(posedge clk);
      check("strobes_outstanding", 64'(strobe_exp_q.size()), 64'h0);
      check("scans_outstanding", 64'(scan_exp_q.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
